pd_loop_filter: RTL and testbench
=================================

// Module: pd_loop_filter
// PURPOSE
//  Digital PI loop filter; reads the TDC phase-error samples and produces the DCO tuning code.
//  - Samples are produced in the refclk domain: a signed int code, plus a toggle per sample.
//  - The block runs on fbclk and crosses each sample in with a toggle synchronizer.
//  - It filters each sample with gain-scheduled PI (acquire/track) and drives dco_code.
// PARAMETERS
//  TDC_RANGE   64   clamp magnitude of incoming error, LSBs
//  CODE_WIDTH  10   dco_code width, unsigned
//  FRAC_BITS   8    integrator fractional bits below dco_code LSB
//  CODE_INIT   512  dco_code / integrator integer part after reset
//  KP_GAIN     4    proportional term = err << KP_GAIN (track)
//  KI_GAIN     0    integrator step = err << KI_GAIN (track)
//  ACQ_BOOST   2    extra left shift on both terms in ACQUIRE
//  LOCK_THRESH 2    |err| <= this counts as in-lock sample
//  LOCK_COUNT  16   consecutive in-lock samples to declare lock
// PORTS
//  fbclk      in  1           feedback clock; all state on posedge
//  resetn     in  1           async active-low reset
//  enable     in  1           1 = filter runs; 0 = hold
//  tdc_out    in  32 (signed) TDC phase error; stable from one tdc_tog change to the next
//  tdc_tog    in  1           toggles once per new tdc_out (refclk domain)
//  dco_code   out CODE_WIDTH  DCO tuning word
//  code_valid out 1           1-cycle pulse when dco_code updates
//  locked     out 1           loop in TRACK state
//  sat        out 1           integrator or output at a limit
// BEHAVIOUR
//  Reset (async):
//   - integ = CODE_INIT<<FRAC_BITS; dco_code = CODE_INIT; code_valid = locked = sat = 0.
//   - State = ACQUIRE; sync flops s1/s2/s3 = 0; lock counter = 0.
//  Sync and arming:
//   - tdc_tog -> s1 -> s2 -> s3; new sample detected when s2 ^ s3.
//   - Edge detect is masked for the first 3 fbclk edges after reset release.
//     No spurious sample is taken if tdc_tog = 1 at reset release.
//  Pipeline and latency (E0 = first edge s1 samples new tdc_tog):
//   - E1: s2 updates.
//   - E2: err_q <= clamp(tdc_out, -TDC_RANGE, +TDC_RANGE).
//   - E3: integ/dco_code update and code_valid = 1 for exactly that cycle.
//   - Latency: 3 fbclk edges.
//  Arithmetic (signed, CODE_WIDTH+FRAC_BITS+8 bits internal, no wrap):
//   - sh = ACQ_BOOST in ACQUIRE, else 0.
//   - integ += err << (KI_GAIN+sh).
//   - integ saturates to [0, (2^CODE_WIDTH-1)<<FRAC_BITS].
//   - sum = integ + (err << (KP_GAIN+sh)).
//   - dco_code = sum >> FRAC_BITS (floor), clamped to [0, 2^CODE_WIDTH-1].
//   - Positive err (feedback late) raises dco_code.
//   - sat = 1 on any update where integ or dco_code hit a limit; cleared on next unclamped update.
//  FSM (HOLD, ACQUIRE, TRACK):
//   - ACQUIRE -> TRACK after LOCK_COUNT consecutive samples with |err| <= LOCK_THRESH.
//     The counter clears on any miss.
//   - TRACK -> ACQUIRE on any sample with |err| > 2*LOCK_THRESH.
//   - Any state -> HOLD when enable = 0; HOLD -> ACQUIRE when enable = 1.
//   - locked = (state == TRACK), registered with the E3 update.
//  HOLD:
//   - dco_code and integ frozen; code_valid = 0; locked = 0.
//   - The sync chain keeps running and detected samples are discarded.
//     Re-enable gives no stale pulse.
//   - enable falling in the same cycle as an E3 update: the update completes, then HOLD.
// CONFIGURATION
//  PD_LOOP_FILTER_LOCK_DET_EN
//   - Defined: FSM, ACQ_BOOST and locked as above.
//   - Undefined: no ACQUIRE/TRACK states; track gains always (sh = 0); locked tied 0.
//     HOLD/enable behaviour unchanged.
// TESTING
//  T1 reset, macro on, one sample tdc_out = +64 -> dco_code 512 -> 529 (boosted), code_valid 1 cycle, 3 edges after E0
//  T2 macro off, one sample tdc_out = +64 -> dco_code 516; tdc_out = +200 -> same as +64 (clamp)
//  T3 repeated tdc_out = +64 -> dco_code rises monotonically to 1023 and sticks, sat = 1, never wraps to 0
//  T4 16 samples tdc_out = 0 -> locked = 1 with 16th code_valid; then tdc_out = +5 -> locked = 0 next update
//  T5 enable = 0, 5 tdc_tog toggles -> dco_code frozen, no code_valid; enable = 1 -> no pulse until next toggle
//  T6 resetn pulsed mid-run with tdc_tog = 1 -> dco_code = 512, code_valid stays 0 after release until next toggle

Source files
------------

// File: rtl/pd_loop_filter_if.sv
// TDC-sample / DCO-code bundle between the phase detector side and the PI loop filter.
`timescale 1ns/1ps
interface pd_loop_filter_if #(
    parameter int CODE_WIDTH = 10
);
    logic signed [31:0]      tdc_out;
    logic                    tdc_tog;
    logic                    enable;
    logic [CODE_WIDTH-1:0]   dco_code;
    logic                    code_valid;
    logic                    locked;
    logic                    sat;

    modport master (
        output tdc_out, tdc_tog, enable,
        input  dco_code, code_valid, locked, sat
    );

    modport slave (
        input  tdc_out, tdc_tog, enable,
        output dco_code, code_valid, locked, sat
    );
endinterface

// File: rtl/pd_loop_filter.sv
// Gain-scheduled digital PI loop filter: TDC phase error in (toggle-synchronised), DCO code out.
// Optional lock detector / ACQUIRE-TRACK gain scheduling: define PD_LOOP_FILTER_LOCK_DET_EN.
`timescale 1ns/1ps
module pd_loop_filter #(
    parameter int TDC_RANGE   = 64,
    parameter int CODE_WIDTH  = 10,
    parameter int FRAC_BITS   = 8,
    parameter int CODE_INIT   = 512,
    parameter int KP_GAIN     = 4,
    parameter int KI_GAIN     = 0,
    parameter int ACQ_BOOST   = 2,
    parameter int LOCK_THRESH = 2,
    parameter int LOCK_COUNT  = 16
) (
    input  logic              fbclk,
    input  logic              resetn,
    pd_loop_filter_if.slave   lf
);
    localparam int IW  = CODE_WIDTH + FRAC_BITS + 8;
    localparam int EW  = $clog2(TDC_RANGE + 1) + 1;
    localparam logic signed [IW-1:0] INTEG_INIT = IW'(CODE_INIT << FRAC_BITS);
    localparam logic signed [IW-1:0] INTEG_MAX  = IW'(((1 << CODE_WIDTH) - 1) << FRAC_BITS);
    localparam logic signed [IW-1:0] CODE_MAX_S = IW'((1 << CODE_WIDTH) - 1);
    localparam logic signed [31:0]   RANGE_P    = 32'(TDC_RANGE);
    localparam logic signed [31:0]   RANGE_N    = -32'(TDC_RANGE);

`ifdef PD_LOOP_FILTER_LOCK_DET_EN
    typedef enum logic [1:0] {HOLD, ACQUIRE, TRACK} state_t;
    localparam state_t RUN_ENTRY = ACQUIRE;
    localparam int LCW = $clog2(LOCK_COUNT + 1);
    logic [LCW-1:0] lock_cnt_reg;
    logic           locked_reg;
    logic [EW-1:0]  err_abs;
    logic           in_lock, big_miss;
`else
    typedef enum logic {HOLD, RUN} state_t;
    localparam state_t RUN_ENTRY = RUN;
`endif

    state_t                 state_reg;
    logic                   s1_reg, s2_reg, s3_reg;
    logic [1:0]             arm_cnt_reg;
    logic                   err_v_reg;
    logic signed [EW-1:0]   err_q_reg;
    logic signed [EW-1:0]   err_clamp;
    logic signed [IW-1:0]   integ_reg;
    logic [CODE_WIDTH-1:0]  dco_code_reg;
    logic                   code_valid_reg, sat_reg;

    logic                   detect;
    logic [4:0]             ki_sh, kp_sh;
    logic signed [IW-1:0]   err_ext, integ_raw, integ_next, sum, code_raw;
    logic [CODE_WIDTH-1:0]  code_next;
    logic                   at_limit;

    // Toggle edges are ignored until the chain has flushed whatever tdc_tog was at release.
    assign detect = (s2_reg ^ s3_reg) && (arm_cnt_reg == 2'd3);

    always_comb begin
        if (lf.tdc_out > RANGE_P)
            err_clamp = EW'(RANGE_P);
        else if (lf.tdc_out < RANGE_N)
            err_clamp = EW'(RANGE_N);
        else
            err_clamp = EW'(lf.tdc_out);
    end

    always_comb begin
        ki_sh = 5'(KI_GAIN);
        kp_sh = 5'(KP_GAIN);
`ifdef PD_LOOP_FILTER_LOCK_DET_EN
        if (state_reg == ACQUIRE) begin
            ki_sh = 5'(KI_GAIN + ACQ_BOOST);
            kp_sh = 5'(KP_GAIN + ACQ_BOOST);
        end
`endif
        err_ext   = {{(IW-EW){err_q_reg[EW-1]}}, err_q_reg};
        integ_raw = integ_reg + (err_ext <<< ki_sh);
        if (integ_raw[IW-1])
            integ_next = '0;
        else if (integ_raw > INTEG_MAX)
            integ_next = INTEG_MAX;
        else
            integ_next = integ_raw;
        sum      = integ_next + (err_ext <<< kp_sh);
        code_raw = sum >>> FRAC_BITS;
        if (code_raw[IW-1])
            code_next = '0;
        else if (code_raw > CODE_MAX_S)
            code_next = '1;
        else
            code_next = code_raw[CODE_WIDTH-1:0];
        at_limit = (integ_next == '0) || (integ_next == INTEG_MAX) ||
                   (code_next == '0) || (code_next == '1);
    end

`ifdef PD_LOOP_FILTER_LOCK_DET_EN
    always_comb begin
        err_abs  = err_q_reg[EW-1] ? EW'(-err_q_reg) : EW'(err_q_reg);
        in_lock  = err_abs <= EW'(LOCK_THRESH);
        big_miss = err_abs >  EW'(2 * LOCK_THRESH);
    end
`endif

    always_ff @(posedge fbclk or negedge resetn) begin
        if (!resetn) begin
            s1_reg         <= 1'b0;
            s2_reg         <= 1'b0;
            s3_reg         <= 1'b0;
            arm_cnt_reg    <= 2'd0;
            err_v_reg      <= 1'b0;
            err_q_reg      <= '0;
            integ_reg      <= INTEG_INIT;
            dco_code_reg   <= CODE_WIDTH'(CODE_INIT);
            code_valid_reg <= 1'b0;
            sat_reg        <= 1'b0;
            state_reg      <= RUN_ENTRY;
`ifdef PD_LOOP_FILTER_LOCK_DET_EN
            lock_cnt_reg   <= '0;
            locked_reg     <= 1'b0;
`endif
        end else begin
            s1_reg <= lf.tdc_tog;
            s2_reg <= s1_reg;
            s3_reg <= s2_reg;
            if (arm_cnt_reg != 2'd3)
                arm_cnt_reg <= arm_cnt_reg + 2'd1;

            // Samples arriving while disabled are dropped here, so re-enable never replays one.
            err_v_reg <= detect && lf.enable;
            if (detect)
                err_q_reg <= err_clamp;

            code_valid_reg <= 1'b0;
            if (err_v_reg && state_reg != HOLD) begin
                integ_reg      <= integ_next;
                dco_code_reg   <= code_next;
                code_valid_reg <= 1'b1;
                sat_reg        <= at_limit;
`ifdef PD_LOOP_FILTER_LOCK_DET_EN
                if (state_reg == ACQUIRE) begin
                    if (!in_lock) begin
                        lock_cnt_reg <= '0;
                    end else if (lock_cnt_reg == LCW'(LOCK_COUNT - 1)) begin
                        lock_cnt_reg <= '0;
                        state_reg    <= TRACK;
                        locked_reg   <= 1'b1;
                    end else begin
                        lock_cnt_reg <= lock_cnt_reg + 1'b1;
                    end
                end else if (big_miss) begin
                    state_reg  <= ACQUIRE;
                    locked_reg <= 1'b0;
                end
`endif
            end

            // Placed after the update so a coincident E3 update still lands before HOLD.
            if (!lf.enable) begin
                state_reg <= HOLD;
`ifdef PD_LOOP_FILTER_LOCK_DET_EN
                lock_cnt_reg <= '0;
                locked_reg   <= 1'b0;
`endif
            end else if (state_reg == HOLD) begin
                state_reg <= RUN_ENTRY;
            end
        end
    end

    assign lf.dco_code   = dco_code_reg;
    assign lf.code_valid = code_valid_reg;
    assign lf.sat        = sat_reg;
`ifdef PD_LOOP_FILTER_LOCK_DET_EN
    assign lf.locked     = locked_reg;
`else
    assign lf.locked     = 1'b0;
`endif
endmodule

// File: tb/tb_pd_loop_filter.sv
// Directed bench for pd_loop_filter; expectations follow PD_LOOP_FILTER_LOCK_DET_EN.
`timescale 1ns/1ps
module tb_pd_loop_filter;
    logic fbclk  = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   errors = 0;

`ifdef PD_LOOP_FILTER_LOCK_DET_EN
    localparam bit LOCK_EN   = 1'b1;
    localparam int CODE_P64  = 529;
`else
    localparam bit LOCK_EN   = 1'b0;
    localparam int CODE_P64  = 516;
`endif

    pd_loop_filter_if bus ();
    pd_loop_filter dut (.fbclk(fbclk), .resetn(resetn), .lf(bus));

    always #5 fbclk = ~fbclk;

    task automatic check(input string tag, input integer obs, input integer exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One sample: toggle tdc_tog, expect code_valid on the 4th edge after the drive (E3).
    task automatic send(input int v, input bit quiet,
                        output integer code, output integer lk, output integer st);
        int lat;
        bit got;
        @(posedge fbclk); #1;
        bus.tdc_out = v;
        bus.tdc_tog = ~bus.tdc_tog;
        got = 1'b0;
        lat = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(posedge fbclk); #1;
            lat++;
            if (bus.code_valid === 1'b1) got = 1'b1;
        end
        check("latency", got ? lat : -1, 4);
        code = bus.dco_code;
        lk   = bus.locked;
        st   = bus.sat;
        @(posedge fbclk); #1;
        check("pulse_width", bus.code_valid, 0);
        if (!quiet)
            $display("sample tdc_out=%0d -> dco_code=%0d locked=%0d sat=%0d lat=%0d",
                     v, code, lk, st, lat);
    endtask

    task automatic pulse_reset();
        @(posedge fbclk); #3;
        resetn = 1'b0;
        repeat (2) @(posedge fbclk);
        #3 resetn = 1'b1;
        repeat (5) @(posedge fbclk);
    endtask

    initial begin
        integer code, lk, st, prev, frozen;
        int pulses, n;
        bit done;

        bus.enable  = 1'b1;
        bus.tdc_tog = 1'b0;
        bus.tdc_out = 0;

        // Reset state
        repeat (3) @(posedge fbclk);
        #1;
        check("rst_dco_code", bus.dco_code, 512);
        check("rst_code_valid", bus.code_valid, 0);
        check("rst_locked", bus.locked, 0);
        check("rst_sat", bus.sat, 0);
        $display("reset: dco_code=%0d code_valid=%0d", bus.dco_code, bus.code_valid);
        #2 resetn = 1'b1;
        repeat (5) @(posedge fbclk);

        // T1: one +64 sample
        send(64, 1'b0, code, lk, st);
        check("t1_code", code, CODE_P64);
        check("t1_sat", st, 0);
        check("t1_locked", lk, 0);

        // T2: out-of-range sample clamps to +64
        pulse_reset();
        send(200, 1'b0, code, lk, st);
        check("t2_clamp_code", code, CODE_P64);

        // T4: 16 in-lock samples, then a miss
        pulse_reset();
        for (int i = 1; i <= 16; i++) begin
            send(0, 1'b0, code, lk, st);
            check("t4_code", code, 512);
            check("t4_locked", lk, (LOCK_EN && i == 16) ? 1 : 0);
        end
        send(5, 1'b0, code, lk, st);
        check("t4_miss_code", code, 512);
        check("t4_miss_locked", lk, 0);

        // T5: HOLD discards samples, re-enable gives no stale pulse
        frozen = bus.dco_code;
        @(posedge fbclk); #1;
        bus.enable = 1'b0;
        pulses = 0;
        for (int k = 0; k < 5; k++) begin
            bus.tdc_out = 64;
            bus.tdc_tog = ~bus.tdc_tog;
            repeat (6) begin
                @(posedge fbclk); #1;
                if (bus.code_valid !== 1'b0) pulses++;
            end
        end
        check("t5_hold_pulses", pulses, 0);
        check("t5_hold_code", bus.dco_code, frozen);
        check("t5_hold_locked", bus.locked, 0);
        $display("hold: 5 toggles, pulses=%0d dco_code=%0d", pulses, bus.dco_code);
        bus.enable = 1'b1;
        pulses = 0;
        repeat (10) begin
            @(posedge fbclk); #1;
            if (bus.code_valid !== 1'b0) pulses++;
        end
        check("t5_reenable_pulses", pulses, 0);
        send(64, 1'b0, code, lk, st);
        check("t5_after_code", code, CODE_P64);

        // T6: reset mid-run with tdc_tog high
        @(posedge fbclk); #3;
        resetn = 1'b0;
        bus.tdc_tog = 1'b1;
        #1;
        check("t6_rst_code", bus.dco_code, 512);
        check("t6_rst_valid", bus.code_valid, 0);
        repeat (2) @(posedge fbclk);
        #3 resetn = 1'b1;
        pulses = 0;
        repeat (12) begin
            @(posedge fbclk); #1;
            if (bus.code_valid !== 1'b0) pulses++;
        end
        check("t6_no_spurious", pulses, 0);
        $display("reset mid-run: dco_code=%0d pulses=%0d", bus.dco_code, pulses);
        send(64, 1'b0, code, lk, st);
        check("t6_after_code", code, CODE_P64);

        // T3: drive to the upper rail
        prev = code;
        done = 1'b0;
        n = 0;
        while (!done && n < 3000) begin
            send(64, 1'b1, code, lk, st);
            n++;
            check("t3_monotonic", (code >= prev) ? 1 : 0, 1);
            check("t3_no_wrap", (code != 0) ? 1 : 0, 1);
            prev = code;
            if (code == 1023) done = 1'b1;
        end
        check("t3_reached_max", code, 1023);
        $display("rail: reached dco_code=%0d after %0d samples", code, n);
        for (int i = 0; i < 3; i++) begin
            send(64, 1'b0, code, lk, st);
            check("t3_stick_code", code, 1023);
            check("t3_sat", st, 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
